// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding shared by the serial subtractor blocks
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_subtractor_fulladder.sv
// serial_subtractor_fulladder: single-bit full adder cell
module serial_subtractor_fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b as a + ~b + 1, LSB first, with start/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb;
  logic [WIDTH-2:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_d;
  logic             w_sum, w_cout, w_last;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign d      = r_d;
  serial_subtractor_fulladder u_fa (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next state: accept in IDLE, WIDTH cycles of RUN, one DONE cycle
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  // handshake outputs decoded from state
  always_comb begin
    ready = r_state == IDLE;
    busy  = r_state == RUN;
    done  = r_state == DONE;
  end
  // datapath: the final sum bit and borrow go straight into d, so the result
  // shift register only needs to hold the lower WIDTH-1 bits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_d     <= '0;
    end else if (r_state == IDLE && start) begin
      r_sa    <= a;
      r_sb    <= ~b;
      r_carry <= 1'b1;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_res   <= (WIDTH-1)'({w_sum, r_res} >> 1);
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_d <= {~w_cout, w_sum, r_res};
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive scoreboard checks of serial_subtractor
module tb_serial_subtractor;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done;
  logic [W:0]   d;
  logic [W:0]   sb_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           order[256];
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .d(d)
  );
  always #5 clk = ~clk;
  function automatic logic [W:0] exp_d(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] diff;
    diff = x - y;
    return {x < y, diff};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic pop_chk(input string tag);
    logic [W:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_d"}, 32'(d), 32'(e));
    end
  endtask
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    sb_q.push_back(exp_d(x, y));
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(W));
    pop_chk(tag);
    chk({tag, "_borrow"}, 32'(d[W]), 32'(x < y));
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int pulses;
    int j, t;
    logic [7:0] p;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run_op("t1_7m3", 4'd7, 4'd3);
    chk("t1_d_literal", 32'(d), 32'b0_0100);
    run_op("t2_3m7", 4'd3, 4'd7);
    chk("t2_d_literal", 32'(d), 32'b1_1100);
    run_op("c_0m0", 4'd0, 4'd0);
    run_op("c_15m15", 4'd15, 4'd15);
    run_op("c_0m15", 4'd0, 4'd15);
    chk("c_0m15_literal", 32'(d), 32'b1_0001);
    run_op("c_15m0", 4'd15, 4'd0);
    chk("c_15m0_literal", 32'(d), 32'b0_1111);
    // back-to-back with start held high
    @(negedge clk);
    a = 4'd9; b = 4'd4; start = 1'b1;
    @(posedge clk);
    sb_q.push_back(exp_d(4'd9, 4'd4));
    #1;
    a = 4'd2; b = 4'd5;
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk("b2b1_done_early", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    chk("b2b1_done", 32'(done), 32'd1);
    pop_chk("b2b1");
    chk("b2b1_literal", 32'(d), 32'b0_0101);
    @(posedge clk); #1;
    chk("b2b_idle_gap", 32'(ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(exp_d(4'd2, 4'd5));
    #1;
    chk("b2b2_accept6", 32'(busy), 32'd1);
    a = 4'd1; b = 4'd1;
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk("b2b2_done_early", 32'(done), 32'd0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b2_done", 32'(done), 32'd1);
    pop_chk("b2b2");
    chk("b2b2_literal", 32'(d), 32'b1_1101);
    @(posedge clk); #1;
    chk("b2b2_ready", 32'(ready), 32'd1);
    // start pulsed during RUN must be ignored
    @(negedge clk);
    a = 4'd12; b = 4'd2; start = 1'b1;
    @(posedge clk);
    sb_q.push_back(exp_d(4'd12, 4'd2));
    #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("ign_done", 32'(done), 32'd1);
    pop_chk("ign");
    chk("ign_literal", 32'(d), 32'b0_1010);
    @(posedge clk); #1;
    chk("ign_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    chk("ign_no_requeue", 32'(ready), 32'd1);
    // asynchronous reset mid-RUN
    @(negedge clk);
    a = 4'd5; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_d", 32'(d), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("arst_no_done", 32'(pulses), 32'd0);
    run_op("arst_6m6", 4'd6, 4'd6);
    chk("arst_6m6_literal", 32'(d), 32'd0);
    // exhaustive sweep in random order
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      p = order[i][7:0];
      run_op("sweep", p[7:4], p[3:0]);
    end
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
